// File: rtl/cpu_pkg.sv
// Shared fetch definitions: ring-counter mode encodings, opcode length field, fetch FSM states.
package cpu_pkg;

   localparam logic [1:0] MODE_SHORT = 2'b00;
   localparam logic [1:0] MODE_EXT   = 2'b01;
   localparam logic [1:0] MODE_LONG  = 2'b10;

   // Instruction length is encoded in the top two opcode bits.
   localparam int OPC_LEN_MSB = 7;
   localparam int OPC_LEN_LSB = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_INC   = 2'd2,
      ST_VALID = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_len_decode.sv
// Opcode -> instruction byte count (1..3) and ring-counter mode; purely combinational.
// Zero latency, no flow control.
module fetch_len_decode
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] opcode,
   output logic [1:0]        len,
   output logic [1:0]        mode
);

   // Only the length field matters; the remaining opcode bits are deliberately ignored.
   logic unused_opc_bits;
   assign unused_opc_bits = ^opcode[OPC_LEN_LSB-1:0];

   always_comb begin
      len  = 2'd1;
      mode = MODE_SHORT;
      case (opcode[OPC_LEN_MSB:OPC_LEN_LSB])
         2'b00: begin
            len  = 2'd1;
            mode = MODE_SHORT;
         end
         2'b01: begin
            len  = 2'd2;
            mode = MODE_EXT;
         end
         default: begin
            len  = 2'd3;
            mode = MODE_LONG;
         end
      endcase
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetches a 1..3 byte instruction at the PC; 2 cycles per byte when memory is always ready.
// mem_req holds with a stable address until mem_ready; abort flushes to IDLE at the next edge.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   pc_address,
   output logic                pc_count,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_req,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [DATA_W-1:0]   opcode,
   output logic [2*DATA_W-1:0] operand,
   output logic [1:0]          mode,
   output logic                instr_valid,
   output logic                busy
);

   fetch_state_e        state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [DATA_W-1:0]   opcode_q, opcode_d;
   logic [2*DATA_W-1:0] operand_q, operand_d;
   logic [1:0]          len;

   fetch_len_decode #(
      .DATA_W (DATA_W)
   ) u_len_decode (
      .opcode (opcode_q),
      .len    (len),
      .mode   (mode)
   );

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q   <= ST_IDLE;
         idx_q     <= 2'd0;
         opcode_q  <= '0;
         operand_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      opcode_d    = opcode_q;
      operand_d   = operand_q;
      pc_count    = 1'b0;
      mem_req     = 1'b0;
      instr_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               opcode_d  = '0;
               operand_d = '0;
               idx_d     = 2'd0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req = 1'b1;
            if (mem_ready && !abort) begin
               case (idx_q)
                  2'd0:    opcode_d = mem_rdata;
                  2'd1:    operand_d[DATA_W-1:0] = mem_rdata;
                  default: operand_d[2*DATA_W-1:DATA_W] = mem_rdata;
               endcase
               state_d = ST_INC;
            end
         end
         ST_INC: begin
            // Byte 0 was latched on entry, so len already reflects this instruction.
            pc_count = !abort;
            if (({1'b0, idx_q} + 3'd1) < {1'b0, len}) begin
               idx_d   = idx_q + 2'd1;
               state_d = ST_REQ;
            end else begin
               state_d = ST_VALID;
            end
         end
         ST_VALID: begin
            instr_valid = !abort;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d = ST_IDLE;
      end
   end

   assign mem_addr = pc_address;
   assign opcode   = opcode_q;
   assign operand  = operand_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: models PC and byte memory, checks latency, pulses and latched fields.
module tb_instruction_fetch;

   logic        clk;
   logic        clear;
   logic        start;
   logic        abort;
   logic [15:0] pc_address;
   logic        pc_count;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ready;
   logic [7:0]  mem_rdata;
   logic [7:0]  opcode;
   logic [15:0] operand;
   logic [1:0]  mode;
   logic        instr_valid;
   logic        busy;

   logic [7:0]  mem [0:65535];
   int          errors;
   int          checks;
   logic [15:0] stall_addr;
   int          stall_left;

   assign mem_rdata = mem[mem_addr];

   instruction_fetch #(
      .ADDR_W (16),
      .DATA_W (8)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .start       (start),
      .abort       (abort),
      .pc_address  (pc_address),
      .pc_count    (pc_count),
      .mem_addr    (mem_addr),
      .mem_req     (mem_req),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .opcode      (opcode),
      .operand     (operand),
      .mode        (mode),
      .instr_valid (instr_valid),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Start is sampled at edge 0; on return we are 1ns after that edge.
   task automatic do_start();
      start     = 1'b1;
      abort     = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Steps n edges after the start edge, driving memory handshake and PC, recording observations.
   task automatic run_cycles(input int n, input int start_at, input int abort_at,
                             output int vld_cyc, output int nvld, output int pulses,
                             output int overlap, output logic addr_moved,
                             output logic [15:0] last_addr);
      logic        inc;
      logic        have;
      logic [15:0] held;
      vld_cyc = -1; nvld = 0; pulses = 0; overlap = 0; addr_moved = 1'b0;
      last_addr = 16'hxxxx; inc = 1'b0; have = 1'b0; held = '0;
      for (int c = 0; c <= n; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
            if (inc) pc_address = pc_address + 16'd1;
            inc = 1'b0;
         end
         start = (c == start_at);
         abort = (c == abort_at);
         #1;
         if (instr_valid) begin
            nvld++;
            if (vld_cyc < 0) vld_cyc = c;
         end
         if (pc_count) begin
            pulses++;
            inc = 1'b1;
         end
         if (pc_count && mem_req) overlap++;
         if (mem_req && stall_left > 0 && mem_addr == stall_addr) begin
            mem_ready = 1'b0;
            stall_left--;
            if (have && mem_addr !== held) addr_moved = 1'b1;
            held = mem_addr;
            have = 1'b1;
         end else begin
            mem_ready = 1'b1;
         end
         if (mem_req && mem_ready) last_addr = mem_addr;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if ({pc_count, mem_req, instr_valid, busy} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {pc_count, mem_req, instr_valid, busy}); end
      checks++; if ({opcode, operand, mode} !== 26'd0) begin errors++; $display("FAIL reset_fields: got op=%h opr=%h mode=%b expected 0", opcode, operand, mode); end
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_one_byte(input string tag);
      int vc, nv, pu, ov; logic mv; logic [15:0] la;
      pc_address = 16'h00A5;
      stall_left = 0;
      do_start();
      checks++; if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 16'h00A5) begin errors++; $display("FAIL %s_req: got busy=%b req=%b addr=%h expected 1 1 00a5", tag, busy, mem_req, mem_addr); end
      run_cycles(5, -1, -1, vc, nv, pu, ov, mv, la);
      checks++; if (vc !== 2 || nv !== 1) begin errors++; $display("FAIL %s_latency: got cycle=%0d count=%0d expected 2 1", tag, vc, nv); end
      checks++; if (pu !== 1 || ov !== 0) begin errors++; $display("FAIL %s_pulses: got pc_count=%0d overlap=%0d expected 1 0", tag, pu, ov); end
      checks++; if (opcode !== 8'h12 || operand !== 16'h0000 || mode !== 2'b00) begin errors++; $display("FAIL %s_fields: got op=%h opr=%h mode=%b expected 12 0000 00", tag, opcode, operand, mode); end
      checks++; if (busy !== 1'b0 || pc_address !== 16'h00A6) begin errors++; $display("FAIL %s_end: got busy=%b pc=%h expected 0 00a6", tag, busy, pc_address); end
   endtask

   task automatic test_two_byte();
      int vc, nv, pu, ov; logic mv; logic [15:0] la;
      pc_address = 16'h00B5;
      stall_left = 0;
      do_start();
      run_cycles(6, -1, -1, vc, nv, pu, ov, mv, la);
      checks++; if (vc !== 4 || nv !== 1) begin errors++; $display("FAIL two_latency: got cycle=%0d count=%0d expected 4 1", vc, nv); end
      checks++; if (pu !== 2 || ov !== 0) begin errors++; $display("FAIL two_pulses: got pc_count=%0d overlap=%0d expected 2 0", pu, ov); end
      checks++; if (opcode !== 8'h45 || operand !== 16'h0034 || mode !== 2'b01) begin errors++; $display("FAIL two_fields: got op=%h opr=%h mode=%b expected 45 0034 01", opcode, operand, mode); end
   endtask

   task automatic test_stall();
      int vc, nv, pu, ov; logic mv; logic [15:0] la;
      pc_address = 16'h0100;
      stall_addr = 16'h0101;
      stall_left = 3;
      do_start();
      run_cycles(11, -1, -1, vc, nv, pu, ov, mv, la);
      checks++; if (vc !== 9 || nv !== 1) begin errors++; $display("FAIL stall_latency: got cycle=%0d count=%0d expected 9 1", vc, nv); end
      checks++; if (pu !== 3 || ov !== 0 || stall_left !== 0) begin errors++; $display("FAIL stall_pulses: got pc_count=%0d overlap=%0d stalls_left=%0d expected 3 0 0", pu, ov, stall_left); end
      checks++; if (mv !== 1'b0) begin errors++; $display("FAIL stall_addr_stable: got moved=%b expected 0", mv); end
      checks++; if (opcode !== 8'h80 || operand !== 16'hABCD || mode !== 2'b10) begin errors++; $display("FAIL stall_fields: got op=%h opr=%h mode=%b expected 80 abcd 10", opcode, operand, mode); end
   endtask

   task automatic test_abort();
      int vc, nv, pu, ov; logic mv; logic [15:0] la;
      pc_address = 16'h0200;
      stall_left = 0;
      do_start();
      run_cycles(8, -1, 2, vc, nv, pu, ov, mv, la);
      checks++; if (pu !== 1 || nv !== 0) begin errors++; $display("FAIL abort_req_counts: got pc_count=%0d valid=%0d expected 1 0", pu, nv); end
      checks++; if (busy !== 1'b0 || opcode !== 8'hC0 || operand !== 16'h0000) begin errors++; $display("FAIL abort_req_state: got busy=%b op=%h opr=%h expected 0 c0 0000", busy, opcode, operand); end
      pc_address = 16'h0210;
      do_start();
      run_cycles(8, -1, 1, vc, nv, pu, ov, mv, la);
      checks++; if (pu !== 0 || nv !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_inc: got pc_count=%0d valid=%0d busy=%b expected 0 0 0", pu, nv, busy); end
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || opcode !== 8'hC0) begin errors++; $display("FAIL abort_start_idle: got busy=%b op=%h expected 0 c0", busy, opcode); end
   endtask

   task automatic test_wrap();
      int vc, nv, pu, ov; logic mv; logic [15:0] la;
      pc_address = 16'hFFFF;
      stall_left = 0;
      do_start();
      run_cycles(8, 2, -1, vc, nv, pu, ov, mv, la);
      checks++; if (la !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h expected 0000", la); end
      checks++; if (vc !== 4 || nv !== 1 || pu !== 2) begin errors++; $display("FAIL wrap_timing: got cycle=%0d count=%0d pc_count=%0d expected 4 1 2", vc, nv, pu); end
      checks++; if (opcode !== 8'h40 || operand !== 16'h005A || mode !== 2'b01 || busy !== 1'b0) begin errors++; $display("FAIL wrap_fields: got op=%h opr=%h mode=%b busy=%b expected 40 005a 01 0", opcode, operand, mode, busy); end
   endtask

   task automatic test_clear_mid();
      pc_address = 16'h0300;
      stall_left = 0;
      do_start();
      mem_ready = 1'b0;
      #2;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL clear_pre_req: got %b expected 1", mem_req); end
      clear = 1'b0;
      #1;
      checks++; if ({pc_count, mem_req, instr_valid, busy} !== 4'b0000 || {opcode, operand, mode} !== 26'd0) begin errors++; $display("FAIL clear_async: got strobes=%b op=%h opr=%h mode=%b expected all 0", {pc_count, mem_req, instr_valid, busy}, opcode, operand, mode); end
      @(posedge clk);
      #1;
      clear = 1'b1;
      test_one_byte("post_clear");
   endtask

   initial begin
      errors = 0; checks = 0;
      clear = 1'b0; start = 1'b0; abort = 1'b0; mem_ready = 1'b0;
      pc_address = 16'h0000; stall_addr = 16'h0000; stall_left = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h00A5] = 8'h12;
      mem[16'h00B5] = 8'h45; mem[16'h00B6] = 8'h34;
      mem[16'h0100] = 8'h80; mem[16'h0101] = 8'hCD; mem[16'h0102] = 8'hAB;
      mem[16'h0200] = 8'hC0; mem[16'h0201] = 8'h11; mem[16'h0202] = 8'h22;
      mem[16'h0210] = 8'hC0;
      mem[16'hFFFF] = 8'h40; mem[16'h0000] = 8'h5A;
      mem[16'h0300] = 8'hC0;
      test_reset();
      test_one_byte("single");
      test_two_byte();
      test_stall();
      test_abort();
      test_wrap();
      test_clear_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning program-counter/memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning memory data/opcode width.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  fetch request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  flush (taken jump/halt); cancels any fetch in progress.
REQ-007 SHALL have port pc_address  input  ADDR_W  current program-counter value.
REQ-008 SHALL have port pc_count  output  1  one-cycle increment strobe to the program counter.
REQ-009 SHALL have port mem_addr  output  ADDR_W  read address, equal to pc_address whenever mem_req is high.
REQ-010 SHALL have port mem_req  output  1  read request, held until accepted.
REQ-011 SHALL have port mem_ready  input  1  memory accept; data valid in the same cycle.
REQ-012 SHALL have port mem_rdata  input  DATA_W  read data.
REQ-013 SHALL have port opcode  output  DATA_W  latched opcode byte.
REQ-014 SHALL have port operand  output  2*DATA_W  latched operand; byte1 in [7:0], byte2 in [15:8].
REQ-015 SHALL have port mode  output  2  ring-counter mode for the fetched instruction.
REQ-016 SHALL have port instr_valid  output  1  one-cycle pulse, instruction complete.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, REQ, INC, VALID; a byte index (0..2) and a length (1..3) select REQ targets.
REQ-019 IDLE: start=1 SHALL clear opcode, operand and byte index to 0 and go to REQ at the next edge.
REQ-020 REQ: mem_req=1; on an edge with mem_ready=1, the SHALL capture mem_rdata into the indexed byte and go to INC.
REQ-021 REQ: mem_ready=0 SHALL hold REQ with mem_req high and mem_addr unchanged, with no timeout.
REQ-022 INC: pc_count=1 and mem_req=0 for exactly one cycle; next state SHALL be REQ if index+1 < length (index incremented), else VALID.
REQ-023 Length SHALL be decoded from opcode[7:6]: 00 -> 1 byte, mode 00; 01 -> 2 bytes, mode 01; 10/11 -> 3 bytes, mode 10.
REQ-024 VALID: instr_valid=1 for one cycle, then the block SHALL return to IDLE; opcode/operand/mode SHALL hold until the next accepted start.
REQ-025 Latency with mem_ready tied high SHALL be instr_valid high exactly 2N cycles after the edge sampling start (N = byte count); exactly N pc_count pulses occur.
REQ-026 abort=1 in any state SHALL force IDLE at the next edge, with no instr_valid, and no pc_count that cycle; abort has priority over mem_ready and start.
REQ-027 start while busy SHALL be ignored; start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-028 mem_addr SHALL wrap naturally with pc_address (FFFF -> 0000); the block SHALL perform no address arithmetic.
REQ-029 pc_count and mem_req SHALL never be high in the same cycle.

Reset
REQ-030 clear low SHALL immediately force IDLE, with pc_count, mem_req, instr_valid and busy at 0, opcode and operand at 0, and mode at 00.
REQ-031 Reset mid-fetch SHALL discard partial bytes; the first post-reset fetch SHALL behave identically to a fresh fetch.

Structure
REQ-032 A shared package cpu_pkg SHALL hold mode encodings (MODE_SHORT=00, MODE_EXT=01, MODE_LONG=10), the opcode length field position, and the fetch state enum.
REQ-033 Sub-module fetch_len_decode (combinational, opcode -> length, mode) SHALL be the only child instance.

Verification
REQ-034 The bench SHALL cover: pc=00A5, start, mem_ready=1, rdata=0x12 -> opcode 12, mode 00, one pc_count, instr_valid 2 cycles after start.
REQ-035 The bench SHALL cover: pc=00B5, rdata sequence 0x45,0x34 -> opcode 45, operand 0034, mode 01, two pc_count pulses, instr_valid at cycle 4.
REQ-036 The bench SHALL cover: opcode 0x80, operands 0xCD,0xAB, mem_ready low 3 cycles on byte 1 -> operand ABCD, mode 10, mem_addr stable during stall, instr_valid at cycle 9.
REQ-037 The bench SHALL cover: abort coincident with mem_ready on byte 1 of a 3-byte fetch -> IDLE next cycle, no pc_count, no instr_valid, busy=0.
REQ-038 The bench SHALL cover: pc=FFFF, 2-byte fetch -> second mem_addr 0000; start asserted during fetch ignored.
REQ-039 The bench SHALL cover: clear pulsed low mid-REQ -> all outputs 0 asynchronously; the subsequent 1-byte fetch matches REQ-034.
